// File: rtl/rf_wb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
//   addr_w()  : register index width for a given register count
//   wb_req_t  : one writeback request (destination + data) at the default sizes
package rf_wb_pkg;

   function automatic int addr_w(input int reg_num);
      return $clog2(reg_num);
   endfunction

   localparam int WB_REG_NUM = 32;
   localparam int WB_ADDR_W  = addr_w(WB_REG_NUM);
   localparam int WB_DATA_W  = 32;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] rd;
      logic [WB_DATA_W-1:0] dat;
   } wb_req_t;

endpackage

// File: rtl/rf_wr_channel_itf.sv
// Register-file write channel. rd = 0 means no write this cycle.
//   out modport : driven by the writeback arbiter
//   in  modport : consumed by the register file array and forward ports
interface RfWrChannelItf #(
   parameter int ADDR_W     = 5,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_W-1:0]     rd;
   logic [DATA_WIDTH-1:0] dat;

   modport out (output rd, output dat);
   modport in  (input rd, input dat);
endinterface

// File: rtl/rf_rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector
//   adv_en     : allow the pointer to move past the granted requester
//   gnt        : one-hot grant (first request at or after ptr)
//   gnt_idx    : index of the granted requester
//   gnt_vld    : some request was granted
module rf_rr_arbiter #(
   parameter  int REQ_NUM = 3,
   localparam int IDX_W   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [REQ_NUM-1:0] req,
   input  logic               adv_en,
   output logic [REQ_NUM-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_vld
);

   localparam int PW = IDX_W + 1;

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic [PW-1:0]    pos;

   // Scan requesters starting at ptr, wrapping modulo REQ_NUM.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      pos     = '0;
      for (int off = 0; off < REQ_NUM; off++) begin
         pos = {1'b0, ptr_q} + PW'(off);
         if (pos >= PW'(REQ_NUM)) begin
            pos = pos - PW'(REQ_NUM);
         end
         if (!gnt_vld && req[pos[IDX_W-1:0]]) begin
            gnt_vld                = 1'b1;
            gnt_idx                = pos[IDX_W-1:0];
            gnt[pos[IDX_W-1:0]]    = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (adv_en && gnt_vld) begin
         ptr_d = (gnt_idx == IDX_W'(REQ_NUM - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Shares the single register-file write port among REQ_NUM writeback
// sources and keeps the per-register busy scoreboard for the issue stage.
//   clk, rst   : clock, asynchronous active-low reset
//   iReqVld    : per-requester write request valid
//   iReqRd     : per-requester destination register
//   iReqDat    : per-requester write data
//   oReqRdy    : per-requester accept (combinational)
//   iIssueVld  : issue of an instruction with a destination register
//   iIssueRd   : destination register of that instruction
//   iFlush     : pipeline flush
//   oWrPort    : registered write channel, rd = 0 means no write
//   oBusy      : scoreboard, bit r set while a write to r is outstanding
module rf_writeback_arbiter
   import rf_wb_pkg::*;
#(
   parameter  int REQ_NUM    = 3,
   parameter  int REG_NUM    = 32,
   parameter  int DATA_WIDTH = 32,
   localparam int ADDR_W     = addr_w(REG_NUM),
   localparam int IDX_W      = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [REQ_NUM-1:0]                  iReqVld,
   input  logic [REQ_NUM-1:0][ADDR_W-1:0]      iReqRd,
   input  logic [REQ_NUM-1:0][DATA_WIDTH-1:0]  iReqDat,
   output logic [REQ_NUM-1:0]                  oReqRdy,
   input  logic                                iIssueVld,
   input  logic [ADDR_W-1:0]                   iIssueRd,
   input  logic                                iFlush,
   RfWrChannelItf.out                          oWrPort,
   output logic [REG_NUM-1:0]                  oBusy
);

   logic [REQ_NUM-1:0]    cand;
   logic [REQ_NUM-1:0]    zero_drop;
   logic [REQ_NUM-1:0]    gnt;
   logic [IDX_W-1:0]      gnt_idx;
   logic                  gnt_vld;
   logic                  gnt_fire;

   logic [ADDR_W-1:0]     wr_rd_q, wr_rd_d;
   logic [DATA_WIDTH-1:0] wr_dat_q, wr_dat_d;
   logic [REG_NUM-1:0]    busy_q, busy_d;

   // Writes to register 0 are swallowed here so they never reach the
   // arbiter and never cost a requester its turn.
   always_comb begin
      cand      = '0;
      zero_drop = '0;
      for (int i = 0; i < REQ_NUM; i++) begin
         cand[i]      = iReqVld[i] && (iReqRd[i] != '0);
         zero_drop[i] = iReqVld[i] && (iReqRd[i] == '0);
      end
   end

   rf_rr_arbiter #(
      .REQ_NUM (REQ_NUM)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst),
      .req     (cand),
      .adv_en  (!iFlush),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   assign gnt_fire = gnt_vld && !iFlush;
   assign oReqRdy  = iFlush ? '0 : (gnt | zero_drop);

   always_comb begin
      wr_rd_d  = '0;
      wr_dat_d = wr_dat_q;
      if (gnt_fire) begin
         wr_rd_d  = iReqRd[gnt_idx];
         wr_dat_d = iReqDat[gnt_idx];
      end
   end

   // Clear on grant, then set on issue, so a same-cycle set wins.
   always_comb begin
      busy_d = busy_q;
      if (iFlush) begin
         busy_d = '0;
      end else begin
         if (gnt_fire) begin
            busy_d[iReqRd[gnt_idx]] = 1'b0;
         end
         if (iIssueVld) begin
            busy_d[iIssueRd] = 1'b1;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_rd_q  <= '0;
         wr_dat_q <= '0;
         busy_q   <= '0;
      end else begin
         wr_rd_q  <= wr_rd_d;
         wr_dat_q <= wr_dat_d;
         busy_q   <= busy_d;
      end
   end

   assign oWrPort.rd  = wr_rd_q;
   assign oWrPort.dat = wr_dat_q;
   assign oBusy       = busy_q;

   // The issue stage must never issue to a register with a write in flight.
   a_no_waw: assert property (@(posedge clk) disable iff (!rst)
      !(iIssueVld && busy_q[iIssueRd]));

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
module tb_rf_writeback_arbiter;
   import rf_wb_pkg::*;

   localparam int N  = 3;
   localparam int RN = 32;
   localparam int DW = 32;
   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]         vld;
   logic [N-1:0][AW-1:0] rd;
   logic [N-1:0][DW-1:0] dat;
   logic [N-1:0]         rdy;
   logic                 issue_vld;
   logic [AW-1:0]        issue_rd;
   logic                 flush;
   logic [RN-1:0]        busy;

   RfWrChannelItf #(.ADDR_W(AW), .DATA_WIDTH(DW)) wr_if ();

   rf_writeback_arbiter #(
      .REQ_NUM    (N),
      .REG_NUM    (RN),
      .DATA_WIDTH (DW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .iReqVld   (vld),
      .iReqRd    (rd),
      .iReqDat   (dat),
      .oReqRdy   (rdy),
      .iIssueVld (issue_vld),
      .iIssueRd  (issue_rd),
      .iFlush    (flush),
      .oWrPort   (wr_if),
      .oBusy     (busy)
   );

   int errors = 0;
   int checks = 0;

   // Behavioural reference state
   int            m_ptr;
   logic [RN-1:0] m_busy;
   wb_req_t       m_out;
   logic [N-1:0]  m_rdy;
   int            m_gnt;
   int            wait_cnt[N];
   logic [N-1:0]  obs_rdy;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr  = 0;
      m_busy = '0;
      m_out  = '0;
      m_rdy  = '0;
      m_gnt  = -1;
      for (int j = 0; j < N; j++) wait_cnt[j] = 0;
   endtask

   // Who should be accepted this cycle, from the current inputs.
   task automatic model_eval();
      m_rdy = '0;
      m_gnt = -1;
      if (!flush) begin
         for (int j = 0; j < N; j++)
            if (vld[j] && rd[j] == 0) m_rdy[j] = 1'b1;
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (m_gnt < 0 && vld[c] && rd[c] != 0) m_gnt = c;
         end
         if (m_gnt >= 0) m_rdy[m_gnt] = 1'b1;
      end
   endtask

   task automatic model_commit();
      if (flush) begin
         m_out.rd = '0;
         m_busy   = '0;
      end else begin
         if (m_gnt >= 0) begin
            m_out.rd  = rd[m_gnt];
            m_out.dat = dat[m_gnt];
            m_ptr     = (m_gnt + 1) % N;
            m_busy[rd[m_gnt]] = 1'b0;
         end else begin
            m_out.rd = '0;
         end
         if (issue_vld && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      end
   endtask

   // One clock: inputs already driven. Returns 1 time unit after the edge.
   task automatic step(input string tag);
      int worst;
      #2;
      model_eval();
      obs_rdy = rdy;
      check({tag, ".rdy"}, 64'(rdy), 64'(m_rdy));
      worst = 0;
      for (int j = 0; j < N; j++) begin
         if (flush) begin
         end else if (vld[j] && rd[j] != 0) begin
            if (rdy[j]) wait_cnt[j] = 0;
            else        wait_cnt[j]++;
         end else begin
            wait_cnt[j] = 0;
         end
         if (wait_cnt[j] > worst) worst = wait_cnt[j];
      end
      check({tag, ".starve"}, 64'(worst <= N - 1), 64'(1));
      @(posedge clk);
      #1;
      model_commit();
      check({tag, ".wr_rd"},  64'(wr_if.rd),  64'(m_out.rd));
      check({tag, ".wr_dat"}, 64'(wr_if.dat), 64'(m_out.dat));
      check({tag, ".busy"},   64'(busy),      64'(m_busy));
   endtask

   task automatic idle_inputs();
      vld       = '0;
      rd        = '0;
      dat       = '0;
      issue_vld = 1'b0;
      issue_rd  = '0;
      flush     = 1'b0;
   endtask

   initial begin
      logic [N-1:0] cont_exp [4];
      int r;
      cont_exp[0] = 3'b001;
      cont_exp[1] = 3'b010;
      cont_exp[2] = 3'b100;
      cont_exp[3] = 3'b001;

      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Reset release, no stimulus
      for (int c = 0; c < 5; c++) step("reset");

      // Single request
      issue_vld = 1'b1; issue_rd = 5'd5;
      step("issue5");
      check("issue5.busy5", 64'(busy[5]), 64'(1));
      issue_vld = 1'b0;
      vld = 3'b010; rd[1] = 5'd5; dat[1] = 32'hDEADBEEF;
      step("single");
      check("single.rdy", 64'(obs_rdy), 64'(3'b010));
      check("single.rd", 64'(wr_if.rd), 64'(5));
      check("single.dat", 64'(wr_if.dat), 64'(32'hDEADBEEF));
      check("single.busy5", 64'(busy[5]), 64'(0));

      // Lone request from 2 returns the pointer to 0
      vld = 3'b100; rd[2] = 5'd8; dat[2] = 32'h0000_0808;
      step("ptr0");
      vld = '0;

      // Contention: all three valid, re-raise with new data after accept
      vld = 3'b111;
      rd[0] = 5'd1; rd[1] = 5'd2; rd[2] = 5'd3;
      dat[0] = 32'h1000_0000; dat[1] = 32'h2000_0000; dat[2] = 32'h3000_0000;
      for (int k = 0; k < 4; k++) begin
         step("cont");
         check("cont.gnt", 64'(obs_rdy), 64'(cont_exp[k]));
         check("cont.rd", 64'(wr_if.rd), 64'((k % 3) + 1));
         for (int j = 0; j < N; j++)
            if (obs_rdy[j]) dat[j] = dat[j] + 32'd1;
      end
      vld[0] = 1'b0;
      step("drain1");
      vld[1] = 1'b0;
      step("drain2");
      vld = '0;

      // Zero register alongside a real write
      vld = 3'b101; rd[0] = 5'd0; rd[2] = 5'd7; dat[0] = 32'hBAD0_0000; dat[2] = 32'h0000_7777;
      step("zero");
      check("zero.rdy", 64'(obs_rdy), 64'(3'b101));
      check("zero.rd", 64'(wr_if.rd), 64'(7));
      vld = 3'b111; rd[0] = 5'd10; rd[1] = 5'd11; rd[2] = 5'd12;
      step("zero.ptr");
      check("zero.ptr0", 64'(obs_rdy), 64'(3'b001));
      vld[0] = 1'b0;
      step("zero.drain1");
      vld[1] = 1'b0;
      step("zero.drain2");
      vld = '0;

      // Set/clear collision: set wins
      vld = 3'b001; rd[0] = 5'd9; dat[0] = 32'h0909_0909;
      issue_vld = 1'b1; issue_rd = 5'd9;
      step("collide");
      check("collide.busy9", 64'(busy[9]), 64'(1));
      check("collide.rd", 64'(wr_if.rd), 64'(9));
      idle_inputs();

      // Flush with a write in the output stage
      issue_vld = 1'b1; issue_rd = 5'd3;
      step("fl.iss3");
      issue_rd = 5'd4;
      step("fl.iss4");
      issue_vld = 1'b0;
      vld = 3'b001; rd[0] = 5'd3; dat[0] = 32'h0303_0303;
      step("fl.wr3");
      vld = 3'b010; rd[1] = 5'd4; dat[1] = 32'h0404_0404;
      issue_vld = 1'b1; issue_rd = 5'd6;
      flush = 1'b1;
      #2;
      check("flush.inflight_rd", 64'(wr_if.rd), 64'(3));
      step("flush");
      check("flush.rdy", 64'(obs_rdy), 64'(0));
      check("flush.rd", 64'(wr_if.rd), 64'(0));
      check("flush.busy", 64'(busy), 64'(0));
      check("flush.busy6", 64'(busy[6]), 64'(0));
      flush = 1'b0; issue_vld = 1'b0;
      step("fl.after");
      check("fl.after.rd", 64'(wr_if.rd), 64'(4));
      idle_inputs();
      step("fl.idle");

      // Randomized traffic
      for (int c = 0; c < 300; c++) begin
         for (int j = 0; j < N; j++) begin
            if (vld[j] && m_rdy[j]) vld[j] = 1'b0;
            if (!vld[j] && $urandom_range(0, 3) != 0) begin
               vld[j] = 1'b1;
               rd[j]  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, RN - 1));
               dat[j] = $urandom();
            end
         end
         flush     = ($urandom_range(0, 15) == 0);
         r         = $urandom_range(1, RN - 1);
         issue_rd  = AW'(r);
         issue_vld = !m_busy[r] && ($urandom_range(0, 1) == 1);
         step("rand");
      end

      // Asynchronous reset mid-operation
      #2 rst = 1'b0;
      #1;
      check("arst.rd", 64'(wr_if.rd), 64'(0));
      check("arst.dat", 64'(wr_if.dat), 64'(0));
      check("arst.busy", 64'(busy), 64'(0));
      idle_inputs();
      model_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      step("arst.idle");
      vld = 3'b111; rd[0] = 5'd20; rd[1] = 5'd21; rd[2] = 5'd22;
      step("arst.ptr");
      check("arst.ptr0", 64'(obs_rdy), 64'(3'b001));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
